iob_wrq: RTL and testbench
==========================

# iob_wrq

Parametrised posted-write queue between the FSB slave side and the IO bus master, generalising the fixed two-level address/data latch pair into a DEPTH-entry FIFO. It accepts FSB IO cycles, acknowledges writes as soon as they are queued, drains them in order to the IO bus master, and orders reads behind all pending writes. Posted-write bus errors are held and reported on the next FSB cycle. A non-posted mode is available for debug.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16.
- AW, 23: address width (A[AW:1]).
- POST, 1: 1 = posted writes; 0 = every write waits for IO completion.
- CLK in 1: FSB clock; all logic rising-edge.
- RES in 1: reset, asynchronous, active-high.
- REQ in 1: single-cycle strobe, FSB IO cycle start; sampled only in IDLE.
- RW in 1: 1 = read, 0 = write; qualified by REQ.
- A in AW: word address; qualified by REQ.
- D in 16: write data; qualified by REQ.
- LDS, UDS in 1 each: active-high byte enables; qualified by REQ.
- READY out 1: one-cycle pulse, terminates FSB cycle normally.
- BERR out 1: one-cycle pulse, terminates FSB cycle with bus error.
- RDATA out 16: read data; valid in the READY cycle, held until next read.
- IOREQ, IORW out 1 each: request and direction to IO bus master.
- IOA out AW, IOD out 16, IOL/IOU out 1 each: head entry fields.
- IOACT in 1: master has accepted the current request.
- IODONE in 1: one-cycle pulse, current IO cycle finished.
- IOBERR in 1: qualified by IODONE; cycle ended with bus error.
- IORDATA in 16: read data; qualified by IODONE.
- COUNT out $clog2(DEPTH)+1: occupied entries.
- EMPTY, FULL out 1 each: COUNT==0 / COUNT==DEPTH.

## Operation
- Storage is DEPTH × (AW+16+2) bits. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- FSM states: IDLE, WFULL, WSYNC, RDRAIN, RBUSY.
- IDLE + REQ + sticky error flag ERRP set: no operation; BERR pulse; clear ERRP; remain IDLE.
- IDLE + write REQ, not FULL: push entry. If POST=1, pulse READY. If POST=0, go to WSYNC.
- IDLE + write REQ, FULL: latch the request and go to WFULL. On the cycle after the next pop, push, pulse READY (or go to WSYNC if POST=0), then go to IDLE.
- WSYNC: wait for that entry's IODONE. Pulse READY, or BERR if IOBERR; ERRP is not set. Return to IDLE.
- IDLE + read REQ: latch the request and go to RDRAIN. When EMPTY and no IO cycle is in flight, issue the read (IORW=1) and go to RBUSY.
- RBUSY: on IODONE, capture IORDATA into RDATA and pulse READY, or pulse BERR if IOBERR. Return to IDLE. Reads are never queued.
- Drain side: IOREQ rises when the head is valid, or a read is issued, and no cycle is in flight.
- IOREQ holds until IOACT is sampled high, then drops. The cycle is in flight until IODONE.
- On IODONE of a queued write: pop the head. If IOBERR and POST=1, set ERRP.
- REQ outside IDLE is ignored. It is illegal by FSB protocol.
- A simultaneous push and pop when not FULL performs both; COUNT is unchanged.
- A simultaneous push and pop when FULL never occurs, because a full write waits in WFULL.
- IODONE without a cycle in flight is ignored.

## Timing
- All outputs are registered. Reset values:
  - READY=0, BERR=0, IOREQ=0, IORW=0.
  - IOA/IOD/IOL/IOU=0, RDATA=0.
  - COUNT=0, EMPTY=1, FULL=0.
  - Pointers=0, ERRP=0, FSM=IDLE.
- Posted write into a non-full queue: READY in cycle N+1 after REQ in cycle N.
- Write into an empty queue: IOREQ in cycle N+1.
- IOREQ drops in the cycle after IOACT is sampled high.
- The next IOREQ may rise in the cycle after IODONE (cycle D+1).
- Full stall: IODONE pops the head in cycle D. The stalled write is pushed in D+1, READY pulses in D+1, and FULL is 1 again in D+2.
- Read with a non-empty queue: IOREQ(read) rises in the cycle after the last write's IODONE. READY and RDATA appear in the cycle after the read's IODONE.
- RES asserted mid-operation: immediately returns all state to reset values and discards the queue and any latched request. In-flight IODONE pulses arriving after RES is released are ignored.

## Test plan
- Posted writes (DEPTH=4, POST=1):
  - Stimulus: 3 writes to $EFE1FE, $EFE3FE, $EFE5FE with D=$1234/$5678/$9ABC. IOACT and IODONE each 4 cycles late.
  - Required: READY 1 cycle after each REQ; COUNT peaks at 3; IOA/IOD appear in order; EMPTY=1 after the third IODONE.
- Full stall:
  - Stimulus: 5 writes, master stalled.
  - Required: FULL=1 after the 4th write; 5th write has no READY. First IODONE releases it: READY pulses in the next cycle and COUNT returns to 4.
- Read ordering:
  - Stimulus: 2 queued writes, then a read of $DFE1FF with IORDATA=$00A5.
  - Required: read IOREQ only after the 2nd IODONE; READY with RDATA=$00A5 one cycle after the read's IODONE.
- Posted error:
  - Stimulus: IOBERR=1 on the first queued write's IODONE, then a new write REQ.
  - Required: the new REQ gets BERR (no READY) and is not queued; the following REQ gets READY.
- Non-posted mode (POST=0):
  - Stimulus: write with IODONE arriving 6 cycles after IOREQ.
  - Required: READY in the cycle after IODONE; COUNT never exceeds 1.
- Reset mid-drain:
  - Stimulus: RES pulse with COUNT=3 and IOREQ=1, followed by a stray IODONE.
  - Required: all outputs return to reset values asynchronously; the stray IODONE leaves COUNT=0.

Source files
------------

// File: rtl/iob_wrq.sv
// Posted-write queue between the FSB slave side and the IO bus master.
// Writes are acknowledged once queued, drained in order; reads wait for an empty queue.
module iob_wrq #(
  parameter int DEPTH = 4,
  parameter int AW    = 23,
  parameter bit POST  = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RES,
  input  logic                     REQ,
  input  logic                     RW,
  input  logic [AW:1]              A,
  input  logic [15:0]              D,
  input  logic                     LDS,
  input  logic                     UDS,
  output logic                     READY,
  output logic                     BERR,
  output logic [15:0]              RDATA,
  output logic                     IOREQ,
  output logic                     IORW,
  output logic [AW:1]              IOA,
  output logic [15:0]              IOD,
  output logic                     IOL,
  output logic                     IOU,
  input  logic                     IOACT,
  input  logic                     IODONE,
  input  logic                     IOBERR,
  input  logic [15:0]              IORDATA,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [2:0]               dbgState
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + 18;

  // FSB handshake: REQ is a one-cycle strobe honoured only in IDLE; each
  // accepted cycle ends with exactly one READY or BERR pulse. IO side: IOREQ
  // holds until IOACT is sampled, the cycle stays in flight until IODONE.
  typedef enum logic [2:0] {IDLE, WFULL, WSYNC, RDRAIN, RBUSY} stateT;

  stateT         state, stateNext;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail, headNext;
  logic [EW-1:0] reqEntry, pushEntry, headEntry, issueEntry;
  logic [CW-1:0] countAfterPop, countNext;
  logic          inFlight, curRead, errp, pendPush;
  logic          doneNow, popNow, push, canIssue, issueRead, issueWrite;
  logic          readyNext, berrNext, errpClr, latchReq, setPend, loadRdata, pushIdle;

  assign dbgState      = state;
  assign doneNow       = IODONE & inFlight;
  assign popNow        = doneNow & ~curRead;
  assign push          = pushIdle | pendPush;
  assign pushEntry     = pendPush ? reqEntry : {A, D, UDS, LDS};
  assign countAfterPop = COUNT - CW'(popNow);
  assign countNext     = countAfterPop + CW'(push);
  assign headNext      = head + PW'(popNow);
  assign canIssue      = ~inFlight | doneNow;
  // A read goes out only once every earlier write has completed.
  assign issueRead     = (state == RDRAIN) & canIssue & (countAfterPop == '0) & ~pendPush;
  assign issueWrite    = canIssue & ~issueRead & ((countAfterPop != '0) | push);
  // Entry written this cycle becomes the head when the queue is otherwise empty.
  assign headEntry     = (countAfterPop == '0) ? pushEntry : mem[headNext];
  assign issueEntry    = issueRead ? reqEntry : headEntry;

  always_comb begin
    stateNext = state;
    readyNext = 1'b0;
    berrNext  = 1'b0;
    errpClr   = 1'b0;
    latchReq  = 1'b0;
    setPend   = 1'b0;
    loadRdata = 1'b0;
    pushIdle  = 1'b0;
    case (state)
      IDLE: begin
        if (REQ && !pendPush) begin
          if (errp) begin
            berrNext = 1'b1;
            errpClr  = 1'b1;
          end else if (RW) begin
            latchReq  = 1'b1;
            stateNext = RDRAIN;
          end else if (!FULL) begin
            pushIdle = 1'b1;
            if (POST) readyNext = 1'b1;
            else      stateNext = WSYNC;
          end else begin
            latchReq  = 1'b1;
            stateNext = WFULL;
          end
        end
      end
      WFULL: begin
        // The stalled write enters the slot freed by this pop on the next cycle.
        if (popNow) begin
          setPend = 1'b1;
          if (POST) begin
            readyNext = 1'b1;
            stateNext = IDLE;
          end else begin
            stateNext = WSYNC;
          end
        end
      end
      WSYNC: begin
        if (popNow && !pendPush) begin
          if (IOBERR) berrNext  = 1'b1;
          else        readyNext = 1'b1;
          stateNext = IDLE;
        end
      end
      RDRAIN: begin
        if (issueRead) stateNext = RBUSY;
      end
      RBUSY: begin
        if (doneNow && curRead) begin
          if (IOBERR) begin
            berrNext = 1'b1;
          end else begin
            readyNext = 1'b1;
            loadRdata = 1'b1;
          end
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[tail] <= pushEntry;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      COUNT    <= '0;
      EMPTY    <= 1'b1;
      FULL     <= 1'b0;
      READY    <= 1'b0;
      BERR     <= 1'b0;
      RDATA    <= '0;
      IOREQ    <= 1'b0;
      IORW     <= 1'b0;
      IOA      <= '0;
      IOD      <= '0;
      IOL      <= 1'b0;
      IOU      <= 1'b0;
      inFlight <= 1'b0;
      curRead  <= 1'b0;
      errp     <= 1'b0;
      pendPush <= 1'b0;
      reqEntry <= '0;
    end else begin
      state    <= stateNext;
      READY    <= readyNext;
      BERR     <= berrNext;
      pendPush <= setPend;
      head     <= headNext;
      COUNT    <= countNext;
      EMPTY    <= (countNext == '0);
      FULL     <= (countNext == CW'(DEPTH));
      if (push)      tail     <= tail + PW'(1);
      if (latchReq)  reqEntry <= {A, D, UDS, LDS};
      if (loadRdata) RDATA    <= IORDATA;
      if (popNow && IOBERR && POST) errp <= 1'b1;
      else if (errpClr)             errp <= 1'b0;
      if (issueRead || issueWrite) begin
        IOREQ    <= 1'b1;
        IORW     <= issueRead;
        inFlight <= 1'b1;
        curRead  <= issueRead;
        IOA      <= issueEntry[EW-1:18];
        IOD      <= issueEntry[17:2];
        IOU      <= issueEntry[1];
        IOL      <= issueEntry[0];
      end else begin
        if (IOACT)   IOREQ    <= 1'b0;
        if (doneNow) inFlight <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iob_wrq.sv
// Directed bench for iob_wrq: posted writes, full stall, read ordering,
// posted bus error, non-posted mode and reset mid-drain.
module tb_iob_wrq;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        req = 1'b0, rw = 1'b0, lds = 1'b0, uds = 1'b0;
  logic [23:1] a = '0;
  logic [15:0] d = '0;
  logic        ioact = 1'b0, iodone = 1'b0, ioberr = 1'b0;
  logic [15:0] iordata = '0;

  logic        ready, berr, ioreq, iorw, iol, iou, empty, full;
  logic [15:0] rdata, iod;
  logic [23:1] ioa;
  logic [2:0]  count, dbgState;

  logic        npReady, npBerr, npIoreq, npIorw, npIol, npIou, npEmpty, npFull;
  logic [15:0] npRdata, npIod;
  logic [23:1] npIoa;
  logic [2:0]  npCount, npDbgState;

  int nChk = 0;
  int nErr = 0;

  logic [23:0] wByte [5] = '{24'hEFE1FE, 24'hEFE3FE, 24'hEFE5FE, 24'hEFE7FE, 24'hEFE9FE};
  logic [15:0] wData [5] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h1357};
  logic [23:0] rByte = 24'hDFE1FF;

  iob_wrq #(.DEPTH(4), .AW(23), .POST(1'b1)) u_dut (
    .CLK(clk), .RES(res), .REQ(req), .RW(rw), .A(a), .D(d), .LDS(lds), .UDS(uds),
    .READY(ready), .BERR(berr), .RDATA(rdata), .IOREQ(ioreq), .IORW(iorw),
    .IOA(ioa), .IOD(iod), .IOL(iol), .IOU(iou), .IOACT(ioact), .IODONE(iodone),
    .IOBERR(ioberr), .IORDATA(iordata), .COUNT(count), .EMPTY(empty), .FULL(full),
    .dbgState(dbgState)
  );

  iob_wrq #(.DEPTH(4), .AW(23), .POST(1'b0)) u_np (
    .CLK(clk), .RES(res), .REQ(req), .RW(rw), .A(a), .D(d), .LDS(lds), .UDS(uds),
    .READY(npReady), .BERR(npBerr), .RDATA(npRdata), .IOREQ(npIoreq), .IORW(npIorw),
    .IOA(npIoa), .IOD(npIod), .IOL(npIol), .IOU(npIou), .IOACT(ioact), .IODONE(iodone),
    .IOBERR(ioberr), .IORDATA(iordata), .COUNT(npCount), .EMPTY(npEmpty), .FULL(npFull),
    .dbgState(npDbgState)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
  endtask

  task automatic fsbWrite(input logic [23:0] ba, input logic [15:0] wd);
    req = 1'b1; rw = 1'b0; a = ba[23:1]; d = wd; lds = 1'b1; uds = 1'b1;
    cyc();
    req = 1'b0;
  endtask

  task automatic fsbRead(input logic [23:0] ba);
    req = 1'b1; rw = 1'b1; a = ba[23:1]; lds = 1'b1; uds = 1'b1;
    cyc();
    req = 1'b0;
  endtask

  // Slow master on the posted instance: accept late, complete later.
  task automatic serve(input logic berrIn, input logic [15:0] rd);
    int n;
    n = 0;
    while (!ioreq && n < 50) begin
      cyc();
      n++;
    end
    chk("ioreqSeen", ioreq, 1);
    repeat (3) cyc();
    ioact = 1'b1;
    cyc();
    ioact = 1'b0;
    chk("ioreqDrop", ioreq, 0);
    repeat (3) cyc();
    iodone = 1'b1; ioberr = berrIn; iordata = rd;
    cyc();
    iodone = 1'b0; ioberr = 1'b0; iordata = '0;
  endtask

  initial begin
    logic [23:0] tmp;
    // Reset state
    @(posedge clk);
    #1;
    chk("rstReady", ready, 0);
    chk("rstBerr", berr, 0);
    chk("rstIoreq", ioreq, 0);
    chk("rstIorw", iorw, 0);
    chk("rstIoa", ioa, 0);
    chk("rstIod", iod, 0);
    chk("rstRdata", rdata, 0);
    chk("rstCount", count, 0);
    chk("rstEmpty", empty, 1);
    chk("rstFull", full, 0);
    chk("rstState", dbgState, 0);
    chk("rstNpCount", npCount, 0);
    chk("rstNpEmpty", npEmpty, 1);
    #1 res = 1'b0;

    // Posted writes
    doReset();
    for (int i = 0; i < 3; i++) begin
      fsbWrite(wByte[i], wData[i]);
      chk("pwReady", ready, 1);
      chk("pwCount", count, i + 1);
      chk("pwIoreq", ioreq, 1);
      tmp = wByte[0];
      chk("pwIoaHead", ioa, tmp[23:1]);
      cyc();
      chk("pwReadyLow", ready, 0);
    end
    chk("pwFull", full, 0);
    for (int i = 0; i < 3; i++) begin
      tmp = wByte[i];
      chk("pwIoa", ioa, tmp[23:1]);
      chk("pwIod", iod, wData[i]);
      serve(1'b0, 16'h0000);
      chk("pwCountDrain", count, 2 - i);
      chk("pwIoreqNext", ioreq, (i < 2) ? 1 : 0);
    end
    chk("pwEmpty", empty, 1);

    // Full stall
    doReset();
    for (int i = 0; i < 4; i++) begin
      fsbWrite(wByte[i], wData[i]);
      chk("fsReady", ready, 1);
      cyc();
    end
    chk("fsFull", full, 1);
    chk("fsCount4", count, 4);
    fsbWrite(wByte[4], wData[4]);
    chk("fsNoReady", ready, 0);
    chk("fsNoBerr", berr, 0);
    chk("fsStateWfull", dbgState, 1);
    repeat (2) cyc();
    chk("fsStillNoReady", ready, 0);
    serve(1'b0, 16'h0000);
    chk("fsReadyD1", ready, 1);
    chk("fsCountD1", count, 3);
    tmp = wByte[1];
    chk("fsIoaNext", ioa, tmp[23:1]);
    cyc();
    chk("fsCountD2", count, 4);
    chk("fsFullD2", full, 1);
    chk("fsReadyD2", ready, 0);

    // Read ordering
    doReset();
    for (int i = 0; i < 2; i++) begin
      fsbWrite(wByte[i], wData[i]);
      cyc();
    end
    fsbRead(rByte);
    chk("roNoReady", ready, 0);
    serve(1'b0, 16'h0000);
    chk("roIorwWr", iorw, 0);
    tmp = wByte[1];
    chk("roIoaWr2", ioa, tmp[23:1]);
    serve(1'b0, 16'h0000);
    chk("roIoreqRd", ioreq, 1);
    chk("roIorwRd", iorw, 1);
    chk("roIoaRd", ioa, rByte[23:1]);
    chk("roEmpty", empty, 1);
    serve(1'b0, 16'h00A5);
    chk("roReady", ready, 1);
    chk("roRdata", rdata, 16'h00A5);
    cyc();
    chk("roReadyLow", ready, 0);
    chk("roRdataHeld", rdata, 16'h00A5);

    // Posted error
    doReset();
    fsbWrite(wByte[0], wData[0]);
    chk("peReady", ready, 1);
    serve(1'b1, 16'h0000);
    chk("peCount0", count, 0);
    fsbWrite(wByte[1], wData[1]);
    chk("peBerr", berr, 1);
    chk("peNoReady", ready, 0);
    chk("peNotQueued", count, 0);
    chk("peNoIoreq", ioreq, 0);
    cyc();
    fsbWrite(wByte[2], wData[2]);
    chk("peNextReady", ready, 1);
    chk("peNextBerr", berr, 0);
    chk("peNextCount", count, 1);

    // Non-posted mode
    doReset();
    fsbWrite(wByte[0], wData[0]);
    chk("npNoReady", npReady, 0);
    chk("npCount1", npCount, 1);
    chk("npIoreq", npIoreq, 1);
    ioact = 1'b1;
    cyc();
    ioact = 1'b0;
    chk("npIoreqDrop", npIoreq, 0);
    for (int i = 0; i < 5; i++) begin
      chk("npWaitReady", npReady, 0);
      chk("npCountMax", (npCount <= 3'd1) ? 1 : 0, 1);
      cyc();
    end
    iodone = 1'b1;
    cyc();
    iodone = 1'b0;
    chk("npReady", npReady, 1);
    chk("npBerr", npBerr, 0);
    chk("npCount0", npCount, 0);
    cyc();
    chk("npReadyLow", npReady, 0);

    // Reset mid-drain
    doReset();
    for (int i = 0; i < 3; i++) begin
      fsbWrite(wByte[i], wData[i]);
      cyc();
    end
    chk("rmCount3", count, 3);
    chk("rmIoreq1", ioreq, 1);
    #3 res = 1'b1;
    #1;
    chk("rmAsyncIoreq", ioreq, 0);
    chk("rmAsyncCount", count, 0);
    chk("rmAsyncEmpty", empty, 1);
    chk("rmAsyncIoa", ioa, 0);
    chk("rmAsyncIod", iod, 0);
    chk("rmAsyncState", dbgState, 0);
    @(posedge clk);
    #1 res = 1'b0;
    iodone = 1'b1;
    cyc();
    iodone = 1'b0;
    chk("rmStrayCount", count, 0);
    chk("rmStrayIoreq", ioreq, 0);
    chk("rmStrayReady", ready, 0);
    cyc();
    chk("rmStrayEmpty", empty, 1);

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
